// File: rtl/max7219_driver.sv
// rtl/max7219_driver.sv - MAX7219 8-digit serial driver: init sequence, digit frames, queued updates.
// Optional automatic refresh when MAX7219_AUTO_REFRESH_EN is defined.
module max7219_driver #(
  parameter int unsigned CLK_DIV     = 4,
  parameter logic [3:0]  INTENSITY   = 4'h8,
  parameter int unsigned REFRESH_GAP = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] c0,
  input  logic [7:0] c1,
  input  logic [7:0] c2,
  input  logic [7:0] c3,
  input  logic [7:0] c4,
  input  logic [7:0] c5,
  input  logic [7:0] c6,
  input  logic [7:0] c7,
  input  logic       update,
  output logic       max_clk,
  output logic       max_din,
  output logic       max_cs_n,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  localparam logic [7:0] HRELOAD   = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_HALF = 5'd30;
  localparam logic [3:0] LAST_WORD = 4'd12;
  localparam logic [3:0] FIRST_DIG = 4'd5;

  state_t          state_q, state_d;
  logic [7:0]      hcnt_q, hcnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [3:0]      word_q, word_d;
  logic            init_q, init_d;
  logic            pending_q, pending_d;
  logic            done_q, done_d;
  logic [7:0][7:0] snap_q, snap_d;
  logic            start;
  logic [15:0]     word;
  logic [4:0]      half_idx;
  logic [3:0]      bit_sel;
`ifdef MAX7219_AUTO_REFRESH_EN
  logic [31:0]     rcnt_q, rcnt_d;
`else
  logic            unused_refresh;
  assign unused_refresh = ^REFRESH_GAP;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hcnt_q    <= 8'd0;
      bit_q     <= 5'd0;
      word_q    <= 4'd0;
      init_q    <= 1'b1;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      snap_q    <= '0;
`ifdef MAX7219_AUTO_REFRESH_EN
      rcnt_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      init_q    <= init_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      snap_q    <= snap_d;
`ifdef MAX7219_AUTO_REFRESH_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  // Words 0-4 are the init sequence; digit frames enter at word 5.
  always_comb begin
    word = 16'h0000;
    case (word_q)
      4'd0:    word = 16'h0C01;
      4'd1:    word = 16'h0F00;
      4'd2:    word = 16'h0900;
      4'd3:    word = 16'h0B07;
      4'd4:    word = {12'h0A0, INTENSITY};
      default: word = {4'h0, word_q - 4'd4, snap_q[3'(word_q - FIRST_DIG)]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bit_d     = bit_q;
    word_d    = word_q;
    init_d    = init_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    snap_d    = snap_q;
    start     = update | pending_q | init_q;
`ifdef MAX7219_AUTO_REFRESH_EN
    rcnt_d    = (state_q == IDLE) ? rcnt_q + 32'd1 : 32'd0;
    if (state_q == IDLE && rcnt_q == 32'(REFRESH_GAP - 1)) start = 1'b1;
`endif
    if (state_q != IDLE && update) pending_d = 1'b1;

    case (state_q)
      IDLE: if (start) begin
        state_d   = LOAD;
        hcnt_d    = HRELOAD;
        word_d    = init_q ? 4'd0 : FIRST_DIG;
        init_d    = 1'b0;
        pending_d = 1'b0;
        snap_d    = {c7, c6, c5, c4, c3, c2, c1, c0};
      end
      LOAD: if (hcnt_q == 8'd0) begin
        state_d = SHIFT;
        hcnt_d  = HRELOAD;
        bit_d   = 5'd0;
      end else hcnt_d = hcnt_q - 8'd1;
      // bit_q counts half-periods; even halves have max_clk high.
      SHIFT: if (hcnt_q == 8'd0) begin
        hcnt_d = HRELOAD;
        if (bit_q == LAST_HALF) begin
          state_d = LATCH;
          bit_d   = 5'd0;
        end else bit_d = bit_q + 5'd1;
      end else hcnt_d = hcnt_q - 8'd1;
      LATCH: if (hcnt_q == 8'd0) begin
        state_d = GAP;
        hcnt_d  = HRELOAD;
      end else hcnt_d = hcnt_q - 8'd1;
      GAP: if (hcnt_q == 8'd0) begin
        if (word_q == LAST_WORD) begin
          state_d = IDLE;
          done_d  = 1'b1;
          word_d  = 4'd0;
          hcnt_d  = 8'd0;
        end else begin
          state_d = LOAD;
          word_d  = word_q + 4'd1;
          hcnt_d  = HRELOAD;
        end
      end else hcnt_d = hcnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    half_idx   = (bit_q + 5'd1) >> 1;
    bit_sel    = 4'd15 - half_idx[3:0];
    max_cs_n   = !(state_q == LOAD || state_q == SHIFT);
    max_clk    = (state_q == SHIFT) && !bit_q[0];
    max_din    = 1'b0;
    if (state_q == LOAD)  max_din = word[15];
    if (state_q == SHIFT) max_din = word[bit_sel];
    busy       = (state_q != IDLE);
    frame_done = done_q;
  end

endmodule

// File: tb/tb_max7219_driver.sv
// tb/tb_max7219_driver.sv - directed bench for max7219_driver with CLK_DIV = 2 (68-cycle words).
module tb_max7219_driver;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] c0 = 8'h11, c1 = 8'h21, c2 = 8'h32, c3 = 8'hA5;
  logic [7:0] c4 = 8'h54, c5 = 8'h65, c6 = 8'h76, c7 = 8'h87;
  logic       update = 1'b0;
  logic       max_clk, max_din, max_cs_n, busy, frame_done;

  max7219_driver #(.CLK_DIV(2), .INTENSITY(4'h8), .REFRESH_GAP(100)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .update(update), .max_clk(max_clk), .max_din(max_din), .max_cs_n(max_cs_n),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, viol = 0;
  int q_t0[$], q_fd[$], q_low[$];
  logic [15:0] q_word[$];
  logic [15:0] sh;
  int low;
  logic in_word = 1'b0, pcs = 1'b1, pclk = 1'b0, pdin = 1'b0;

  // Decodes words from the serial pins, sampled on the falling system clock edge.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (!reset_n) begin
      in_word = 1'b0; pcs = 1'b1; pclk = 1'b0; pdin = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (frame_done) q_fd.push_back(cyc);
      if (!max_cs_n) begin
        if (pcs) begin in_word = 1'b1; sh = 16'h0; low = 0; q_t0.push_back(cyc); end
        low++;
        if (max_clk && !pclk) sh = {sh[14:0], max_din};
        if (max_clk && pclk && max_din !== pdin) viol++;
      end else if (!pcs && in_word) begin
        q_word.push_back(sh); q_low.push_back(low); in_word = 1'b0;
      end
      pcs = max_cs_n; pclk = max_clk; pdin = max_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  task automatic clear();
    q_t0.delete(); q_fd.delete(); q_low.delete(); q_word.delete(); busy_cnt = 0;
  endtask

  // which: 0 waits for frame_done pulses, 1 for word starts.
  task automatic wait_cnt(input string tag, input int which, input int n, input int bound);
    int k = 0;
    while (((which == 0) ? q_fd.size() : q_t0.size()) < n && k < bound) begin step(1); k++; end
    check(tag, ((which == 0) ? q_fd.size() : q_t0.size()) >= n, 1);
  endtask

  task automatic pulse_update(output int u);
    update = 1'b1; u = cyc; step(1); update = 1'b0;
  endtask

  int rel, u, t0;

  initial begin
    step(5);
    check("rst_cs_n", max_cs_n, 1);
    check("rst_clk", max_clk, 0);
    check("rst_din", max_din, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);

    clear(); reset_n = 1'b1; rel = cyc;
    wait_cnt("init_fd_wait", 0, 1, 2000);
    step(10);
    check("init_start", q_t0[0] - rel, 1);
    check("init_words", q_word.size(), 13);
    check("init_w0", q_word[0], 16'h0C01);
    check("init_w1", q_word[1], 16'h0F00);
    check("init_w4", q_word[4], 16'h0A08);
    check("init_w5", q_word[5], 16'h0111);
    check("init_low", q_low[0], 64);
    check("init_period", q_t0[1] - q_t0[0], 68);
    check("init_fd_time", q_fd[0] - q_t0[0], 884);
    check("init_fd_once", q_fd.size(), 1);
    check("init_busy", busy_cnt, 884);
    check("idle_busy", busy, 0);

    clear(); pulse_update(u);
    wait_cnt("upd_fd_wait", 0, 1, 1000);
    step(10);
    check("upd_start", q_t0[0] - u, 1);
    check("upd_words", q_word.size(), 8);
    check("upd_w0", q_word[0], 16'h0111);
    check("upd_w3", q_word[3], 16'h04A5);
    check("upd_w7", q_word[7], 16'h0887);
    check("upd_len", q_fd[0] - q_t0[0], 544);
    check("upd_busy", busy_cnt, 544);

    clear(); pulse_update(u);
    step(100); pulse_update(u);
    step(100); pulse_update(u);
    wait_cnt("pend_fd_wait", 0, 2, 2000);
    step(800);
    check("pend_frames", q_fd.size(), 2);
    check("pend_words", q_t0.size(), 16);
    check("pend_start", q_t0[8] - q_fd[0], 1);

    clear(); pulse_update(u);
    wait_cnt("snap_t0_wait", 1, 4, 1000);
    c0 = 8'h22;
    wait_cnt("snap_fd_wait", 0, 1, 1000);
    step(5); pulse_update(u);
    wait_cnt("snap_fd2_wait", 0, 2, 1000);
    step(5);
    check("snap_old", q_word[0], 16'h0111);
    check("snap_new", q_word[8], 16'h0122);

    clear(); pulse_update(u);
    wait_cnt("rst_t0_wait", 1, 1, 100);
    t0 = q_t0[0];
    while (cyc < t0 + 20) step(1);
    check("pre_rst_cs_n", max_cs_n, 0);
    reset_n = 1'b0; #1;
    check("mid_rst_cs_n", max_cs_n, 1);
    check("mid_rst_clk", max_clk, 0);
    check("mid_rst_busy", busy, 0);
    step(3);
    clear(); reset_n = 1'b1;
    wait_cnt("rerun_fd_wait", 0, 1, 2000);
    step(5);
    check("rerun_w0", q_word[0], 16'h0C01);
    check("rerun_words", q_word.size(), 13);

    clear(); step(10000);
    check("no_auto", q_t0.size(), 0);
    check("din_stable", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_driver.md
MAX7219_DRIVER -- requirements
Module: max7219_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: the serial clock half-period in CLOCK_50 cycles (H), legal range 1-255.
REQ-002 The block SHALL have parameter INTENSITY, default 4'h8: the value written to register 0x0A.
REQ-003 The block SHALL have parameter REFRESH_GAP, default 50000: the idle cycles between automatic frames (used only under REQ-028).
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports c0..c7, input, 8 bits each: raw segment patterns for digits 0-7.
REQ-007 The block SHALL have port update, input, 1 bit: frame request.
REQ-008 The block SHALL have port max_clk, output, 1 bit: serial clock to the MAX7219.
REQ-009 The block SHALL have port max_din, output, 1 bit: serial data to the MAX7219.
REQ-010 The block SHALL have port max_cs_n, output, 1 bit: active-low load/chip-select.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at frame end.

Function
REQ-013 The state machine SHALL have states IDLE, LOAD, SHIFT, LATCH and GAP.
- IDLE -> LOAD on a frame start.
- LOAD -> SHIFT -> LATCH -> GAP for each word.
- GAP -> LOAD if words remain, else IDLE.
REQ-014 Each word SHALL be 16 bits, sent MSB first: bits 15:12 = 0, bits 11:8 = address, bits 7:0 = data.
REQ-015 Word timing SHALL be relative to the cycle T0 in which max_cs_n falls:
- max_din = bit15 at T0.
- max_clk rises at T0+H, 3H, ... 31H.
- max_clk falls at T0+2H, 4H, ... 32H.
REQ-016 max_din SHALL change only at max_clk falling edges or at T0, never while max_clk is high.
REQ-017 max_cs_n SHALL rise at T0+32H and stay high for 2H cycles; the next word's T0 SHALL be at T0+34H.
REQ-018 The first frame after reset SHALL start in the first cycle after reset_n deasserts and SHALL send 13 words.
- Init words, in order: 0x0C01, 0x0F00, 0x0900, 0x0B07, 0x0A00|INTENSITY.
- Then the 8 digit words.
REQ-019 Every later frame SHALL send the 8 digit words only: word i (i = 0..7) = {4'h0, 4'(i+1), ci}, in ascending i.
REQ-020 c0..c7 SHALL be snapshotted in the frame's first cycle; input changes during a frame SHALL NOT affect that frame.
REQ-021 update high in IDLE SHALL cause max_cs_n to fall on the next cycle.
REQ-022 update high while busy SHALL set one pending flag; any further requests while the flag is set SHALL be absorbed.
REQ-023 A set pending flag SHALL start a new frame on the cycle after frame_done, and SHALL clear at that start.
REQ-024 busy SHALL rise with the first max_cs_n fall and SHALL fall in the same cycle frame_done pulses, which is the cycle after the final GAP ends.
REQ-025 The bit counter and the word counter SHALL wrap only via state transitions.
REQ-026 The half-period counter SHALL be 8 bits wide and SHALL reload to CLK_DIV-1.

Reset
REQ-027 While reset_n is low, outputs SHALL be forced asynchronously to:
- max_cs_n = 1, max_clk = 0, max_din = 0
- busy = 0, frame_done = 0
- state IDLE, pending = 0, counters = 0
Reset mid-word SHALL abandon the word, and the init sequence SHALL re-run on release.

Configuration
REQ-028 Feature macro MAX7219_AUTO_REFRESH_EN controls automatic refresh.
- Defined: IDLE counts REFRESH_GAP cycles after frame_done and then starts a digit frame automatically; update in IDLE still starts a frame immediately and restarts the count.
- Undefined: frames start only on the reset-release init or on update.

Verification
REQ-029 With CLK_DIV = 2, release reset, then check:
- first word = 0x0C01, MSB first.
- max_cs_n low for 64 cycles and high for 4.
- 13 words in total, then frame_done asserts once.
REQ-030 With c3 = 8'hA5, pulse update in IDLE:
- 4th word = 0x04A5.
- frame lasts 8 x 68 = 544 cycles.
- busy is high throughout.
REQ-031 Give two update pulses while busy: exactly one extra frame SHALL follow, starting the cycle after frame_done.
REQ-032 Change c0 from 8'h11 to 8'h22 during word 3: that frame sends 0x0111; the next frame sends 0x0122.
REQ-033 Assert reset_n low at T0+10H: max_cs_n = 1 and max_clk = 0 in the same cycle; after release the first word is 0x0C01.
REQ-034 Auto-refresh check:
- MAX7219_AUTO_REFRESH_EN defined, REFRESH_GAP = 100: frames repeat with a 100-cycle idle gap.
- Undefined: no max_cs_n activity for 10000 cycles after init.
